// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, instruction-memory addressing,
// fetch-window fault detection and the IF/ID pipeline register.
//
// There is no handshake on this block. The stall input is the only flow
// control: stall=1 freezes every register, and nextEnable/NPC are ignored
// for that cycle. The stage contains no FSM.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          IM_WORDS = 1024,
  localparam int         IM_AW    = $clog2(IM_WORDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             nextEnable,
  input  logic [31:0]      NPC,
  input  logic [31:0]      Instr,
  output logic [31:0]      PC,
  output logic [IM_AW-1:0] IM_Addr,
  output logic [31:0]      IR_D,
  output logic [31:0]      PC_D,
  output logic [31:0]      PC4_D,
  output logic [31:0]      PC8_D,
  output logic             Fault_D,
  output logic [31:0]      FetchCount
);

  // The window end is computed in 33 bits so that a window ending exactly at
  // 2^32 does not wrap to zero.
  localparam logic [32:0] WIN_END = {1'b0, RESET_PC} + 33'(4 * IM_WORDS);

  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic [31:0] pc_plus8;
  logic        fault;
  logic [31:0] ir_q;
  logic [31:0] pc_d_q;
  logic [31:0] pc4_d_q;
  logic [31:0] pc8_d_q;
  logic        fault_d_q;
  logic [31:0] fetch_count_q;

  // Sequential PC arithmetic wraps modulo 2^32. A fetch is faulted when it
  // is misaligned or falls outside the memory window.
  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    pc_plus8 = pc_q + 32'd8;
    fault    = (pc_q[1:0] != 2'b00) ||
               (pc_q < RESET_PC) ||
               ({1'b0, pc_q} >= WIN_END);
  end

  // Advance the PC and load IF/ID. The instruction in F when a redirect
  // arrives is kept as the delay slot. Reset overrides stall and redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      ir_q          <= 32'h0;
      pc_d_q        <= RESET_PC;
      pc4_d_q       <= RESET_PC + 32'd4;
      pc8_d_q       <= RESET_PC + 32'd8;
      fault_d_q     <= 1'b0;
      fetch_count_q <= 32'h0;
    end else if (!stall) begin
      pc_q      <= nextEnable ? NPC : pc_plus4;
      ir_q      <= fault ? 32'h0 : Instr;
      pc_d_q    <= pc_q;
      pc4_d_q   <= pc_plus4;
      pc8_d_q   <= pc_plus8;
      fault_d_q <= fault;
      if (!fault) begin
        fetch_count_q <= fetch_count_q + 32'd1;
      end
    end
  end

  assign PC         = pc_q;
  assign IM_Addr    = pc_q[IM_AW+1:2];
  assign IR_D       = ir_q;
  assign PC_D       = pc_d_q;
  assign PC4_D      = pc4_d_q;
  assign PC8_D      = pc8_d_q;
  assign Fault_D    = fault_d_q;
  assign FetchCount = fetch_count_q;

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed scenarios with literal expectations,
// followed by randomized traffic checked against a behavioural model.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int          IM_WORDS = 1024;
  localparam int          IM_AW    = $clog2(IM_WORDS);

  logic             clk;
  logic             reset;
  logic             stall;
  logic             nextEnable;
  logic [31:0]      NPC;
  logic [31:0]      Instr;
  logic [31:0]      PC;
  logic [IM_AW-1:0] IM_Addr;
  logic [31:0]      IR_D;
  logic [31:0]      PC_D;
  logic [31:0]      PC4_D;
  logic [31:0]      PC8_D;
  logic             Fault_D;
  logic [31:0]      FetchCount;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] mem [IM_WORDS];

  // behavioural model state
  bit          m_valid = 0;
  logic [31:0] m_pc, m_ir, m_pc_d, m_pc4, m_pc8, m_cnt;
  logic        m_fault;

  if_stage #(.RESET_PC(RESET_PC), .IM_WORDS(IM_WORDS)) dut (
    .clk(clk), .reset(reset), .stall(stall), .nextEnable(nextEnable),
    .NPC(NPC), .Instr(Instr), .PC(PC), .IM_Addr(IM_Addr), .IR_D(IR_D),
    .PC_D(PC_D), .PC4_D(PC4_D), .PC8_D(PC8_D), .Fault_D(Fault_D),
    .FetchCount(FetchCount)
  );

  // instruction memory answers combinationally
  assign Instr = mem[IM_Addr];

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // apply inputs for one rising edge; returns 2ns after that edge
  task automatic drive(input logic r, input logic s, input logic n, input logic [31:0] npc);
    reset      = r;
    stall      = s;
    nextEnable = n;
    NPC        = npc;
    @(posedge clk);
    #2;
  endtask

  function automatic bit in_fault(input logic [31:0] a);
    longint lo, hi;
    lo = longint'(RESET_PC);
    hi = lo + 4 * IM_WORDS;
    return (a % 4 != 0) || (longint'(a) < lo) || (longint'(a) >= hi);
  endfunction

  // model: what the stage must hold after each rising edge
  always @(posedge clk) begin
    bit f;
    if (reset) begin
      m_valid = 1;
      m_pc    = RESET_PC;
      m_ir    = 32'h0;
      m_pc_d  = RESET_PC;
      m_pc4   = RESET_PC + 4;
      m_pc8   = RESET_PC + 8;
      m_fault = 1'b0;
      m_cnt   = 32'h0;
    end else if (m_valid && !stall) begin
      f       = in_fault(m_pc);
      m_ir    = f ? 32'h0 : mem[int'((m_pc - RESET_PC) / 4)];
      m_pc_d  = m_pc;
      m_pc4   = m_pc + 4;
      m_pc8   = m_pc + 8;
      m_fault = f;
      if (!f) m_cnt = m_cnt + 1;
      m_pc    = nextEnable ? NPC : m_pc + 4;
    end
  end

  // compare DUT against the model on every falling edge once reset has occurred
  always @(negedge clk) begin
    if (m_valid) begin
      check("pc",       PC,                      m_pc);
      check("im_addr",  32'(IM_Addr),            (m_pc / 4) % IM_WORDS);
      check("ir_d",     IR_D,                    m_ir);
      check("pc_d",     PC_D,                    m_pc_d);
      check("pc4_d",    PC4_D,                   m_pc4);
      check("pc8_d",    PC8_D,                   m_pc8);
      check("fault_d",  32'(Fault_D),            32'(m_fault));
      check("fetchcnt", FetchCount,              m_cnt);
    end
  end

  // stimulus
  initial begin
    int pick;
    logic [31:0] npc;
    reset = 1'b1; stall = 1'b0; nextEnable = 1'b0; NPC = 32'h0;
    for (int i = 0; i < IM_WORDS; i++) mem[i] = $urandom;
    mem[4]    = 32'h1111_0004;
    mem[16]   = 32'h2222_0010;
    mem[17]   = 32'h2222_0011;

    // reset state
    drive(1, 0, 0, 32'h0);
    check("rst_pc",    PC,         32'h0000_3000);
    check("rst_ir",    IR_D,       32'h0);
    check("rst_pc_d",  PC_D,       32'h0000_3000);
    check("rst_pc4",   PC4_D,      32'h0000_3004);
    check("rst_pc8",   PC8_D,      32'h0000_3008);
    check("rst_fault", 32'(Fault_D), 32'h0);
    check("rst_cnt",   FetchCount, 32'h0);

    // sequential fetch
    for (int i = 0; i < 4; i++) begin
      check("seq_pc", PC, 32'h0000_3000 + 32'(4 * i));
      drive(0, 0, 0, 32'h0);
      check("seq_pc_d", PC_D, 32'h0000_3000 + 32'(4 * i));
    end
    check("seq_cnt", FetchCount, 32'd4);
    check("seq_pc_end", PC, 32'h0000_3010);

    // redirect with delay slot
    drive(0, 0, 1, 32'h0000_3040);
    check("br_pc",    PC,   32'h0000_3040);
    check("br_slot",  IR_D, 32'h1111_0004);
    check("br_pc_d",  PC_D, 32'h0000_3010);
    drive(0, 0, 0, 32'h0);
    check("br_tgt_ir", IR_D, 32'h2222_0010);
    check("br_tgt_pc", PC,   32'h0000_3044);

    // stall ignores redirect
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 32'h0000_3100);
      check("st_pc",  PC,         32'h0000_3044);
      check("st_ir",  IR_D,       32'h2222_0010);
      check("st_cnt", FetchCount, 32'd6);
    end
    drive(0, 0, 0, 32'h0);
    check("st_rel_pc", PC,   32'h0000_3048);
    check("st_rel_ir", IR_D, 32'h2222_0011);

    // misaligned and out-of-window targets
    drive(0, 0, 1, 32'h0000_3042);
    check("mis_pc",  PC,         32'h0000_3042);
    check("mis_cnt", FetchCount, 32'd8);
    drive(0, 0, 1, 32'h0000_4000);
    check("mis_ir",    IR_D,        32'h0);
    check("mis_fault", 32'(Fault_D), 32'h1);
    check("mis_cnt2",  FetchCount,  32'd8);
    check("oow_pc",    PC,          32'h0000_4000);
    drive(0, 0, 1, 32'h0000_3000);
    check("oow_ir",    IR_D,        32'h0);
    check("oow_fault", 32'(Fault_D), 32'h1);
    check("oow_cnt",   FetchCount,  32'd8);
    drive(0, 0, 0, 32'h0);
    check("back_fault", 32'(Fault_D), 32'h0);
    check("back_cnt",   FetchCount,  32'd9);

    // reset dominates stall and redirect
    drive(0, 0, 0, 32'h0);
    drive(1, 1, 1, 32'h0000_3100);
    check("rd_pc",    PC,         32'h0000_3000);
    check("rd_ir",    IR_D,       32'h0);
    check("rd_pc_d",  PC_D,       32'h0000_3000);
    check("rd_pc8",   PC8_D,      32'h0000_3008);
    check("rd_cnt",   FetchCount, 32'h0);

    // FetchCount wrap
    drive(0, 0, 0, 32'h0);
    force dut.fetch_count_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_count_q;
    drive(0, 0, 0, 32'h0);
    check("wrap_cnt", FetchCount, 32'h0);

    // PC+4/PC+8 wrap at top of address space
    drive(0, 0, 1, 32'hFFFF_FFFC);
    drive(0, 0, 0, 32'h0);
    check("top_pc",  PC,    32'h0000_0000);
    check("top_pc4", PC4_D, 32'h0000_0000);
    check("top_pc8", PC8_D, 32'h0000_0004);

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      pick = $urandom_range(0, 99);
      if (pick < 80)      npc = RESET_PC + 32'(4 * $urandom_range(0, IM_WORDS - 1));
      else if (pick < 88) npc = RESET_PC + 32'($urandom_range(0, 4 * IM_WORDS - 1));
      else if (pick < 96) npc = $urandom;
      else                npc = 32'hFFFF_FFF8;
      drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 20),
            ($urandom_range(0, 99) < 25), npc);
    end
    drive(0, 0, 0, 32'h0);
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, PC value loaded on reset and base of the instruction memory window.
REQ-002 Parameter IM_WORDS, default 1024, instruction memory depth in 32-bit words (power of two); IM_AW = log2(IM_WORDS).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hazard-unit stall; freezes PC and IF/ID register.
REQ-006 nextEnable  input  1  redirect request from branch/jump decode in D (branch taken, j/jal, jr/jalr).
REQ-007 NPC  input  32  redirect target, valid when nextEnable=1.
REQ-008 Instr  input  32  instruction word returned combinationally by instruction memory for IM_Addr.
REQ-009 PC  output  32  current fetch PC (F stage).
REQ-010 IM_Addr  output  IM_AW  word index to instruction memory.
REQ-011 IR_D  output  32  IF/ID instruction register.
REQ-012 PC_D, PC4_D, PC8_D  output  32 each  IF/ID copies of PC, PC+4, PC+8 (PC8_D feeds jal/jalr link).
REQ-013 Fault_D  output  1  IF/ID fetch-fault flag.
REQ-014 FetchCount  output  32  count of valid instructions delivered to D.

Function
REQ-015 PC register SHALL update every rising edge with stall=0: PC <= nextEnable ? NPC : PC+4.
REQ-016 With stall=1, PC, IR_D, PC_D, PC4_D, PC8_D, Fault_D and FetchCount SHALL hold; nextEnable and NPC SHALL be ignored that cycle.
REQ-017 PC+4 and PC+8 SHALL be computed modulo 2^32 (0xFFFF_FFFC+4 = 0x0000_0000).
REQ-018 IM_Addr SHALL equal PC[IM_AW+1:2] combinationally; zero added latency from PC to IM_Addr.
REQ-019 Combinational fault SHALL be 1 when PC[1:0]!=0, or PC<RESET_PC, or PC>=RESET_PC+4*IM_WORDS; else 0.
REQ-020 With stall=0, IF/ID SHALL load: IR_D <= fault ? 32'h0 : Instr; PC_D <= PC; PC4_D <= PC+4; PC8_D <= PC+8; Fault_D <= fault.
REQ-021 Faulted fetch SHALL present a nop (32'h0) to D; PC still advances per REQ-015.
REQ-022 Branch delay slot: the instruction in F in the cycle nextEnable=1 SHALL be latched into IF/ID normally (no flush); the redirect target is fetched the following cycle.
REQ-023 NPC SHALL be accepted unchecked; a misaligned or out-of-window target is flagged by REQ-019 once it becomes PC.
REQ-024 FetchCount SHALL increment by 1 on each edge with stall=0 and fault=0, wrapping 0xFFFF_FFFF -> 0.
REQ-025 One-cycle latency: value on Instr at edge N appears on IR_D after edge N.

Reset
REQ-026 reset SHALL dominate stall and nextEnable.
REQ-027 Reset values: PC=RESET_PC, IR_D=0, PC_D=RESET_PC, PC4_D=RESET_PC+4, PC8_D=RESET_PC+8, Fault_D=0, FetchCount=0.
REQ-028 Reset asserted mid-stall or mid-redirect SHALL discard the pending redirect; first post-reset fetch is at RESET_PC.

Verification
REQ-029 Reset, then 4 cycles stall=0, nextEnable=0 -> PC sequence 0x3000,0x3004,0x3008,0x300C; PC_D lags one cycle; FetchCount=4.
REQ-030 PC=0x3010, nextEnable=1, NPC=0x3040 -> next PC=0x3040; IR_D gets instruction at 0x3010 (delay slot), next IR_D from 0x3040.
REQ-031 stall=1 for 3 cycles with nextEnable=1, NPC=0x3100 -> PC, IR_D, FetchCount unchanged all 3 cycles; stall release with nextEnable=0 -> PC+4.
REQ-032 NPC=0x3042 redirect -> PC=0x3042, next edge IR_D=0, Fault_D=1, FetchCount unchanged; NPC=0x4000 (IM_WORDS=1024) -> same fault response.
REQ-033 reset asserted together with stall=1 and nextEnable=1 -> all outputs at REQ-027 values after the edge.
REQ-034 Force FetchCount to 0xFFFF_FFFF, one valid fetch -> FetchCount=0.
